cp0_ext: RTL and testbench
==========================

Name: cp0_ext

Overview:
Parametrised coprocessor-0 for the pipelined MIPS core; successor to the fixed 6-line CP0 in the M stage.
Holds SR, Cause, EPC, PRId, BadVAddr, Count and Compare.
Arbitrates exceptions and interrupts: a configurable number of hardware lines, two software interrupts, and an internal Count/Compare timer.
Drives Req and EPCOut to the pipeline flush and PC-select logic.

Parameters:
NUM_HWINT, 6, hardware interrupt lines (1..6); mapped to IP/IM bits [10 +: NUM_HWINT]; unused bits read 0
TIMER_EN, 1, 1 = Count/Compare timer present; 0 = Count/Compare read 0 and the timer never fires
PRID, 32'h0000_4B50, constant returned for PRId (address 15)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
enable  in  1  mtc0 write strobe
CP0Address  in  5  register select for read and write
CP0In  in  32  mtc0 write data
CP0Out  out  32  mfc0 read data, combinational
VPC  in  32  PC of the M-stage instruction
BDIn  in  1  M-stage instruction is in a delay slot
ExcCodeIn  in  5  pending exception code; 0 = none
BadVAddrIn  in  32  faulting address for AdEL/AdES
HWInt  in  NUM_HWINT  level-sensitive hardware interrupts
EXLClr  in  1  eret in M stage
EPCOut  out  32  handler return / eret target, combinational
Req  out  1  take exception/interrupt this cycle, combinational

Behaviour:
- Reset (reset=0, async):
  - SR, Cause, EPC, BadVAddr and Count clear to 0.
  - Compare resets to 32'hFFFF_FFFF.
  - Combinational outputs follow from the cleared state, so Req=0.
- Register map: 8 BadVAddr (read-only), 9 Count, 11 Compare, 12 SR, 13 Cause, 14 EPC, 15 PRId (read-only). Any other address reads 0; writes to it are ignored.
- SR fields:
  - IE = bit 0; EXL = bit 1.
  - IM_SW = bits [9:8]; IM_HW = [10 +: NUM_HWINT]. Remaining bits are write-ignored and read 0.
- Cause fields:
  - BD = bit 31; TI = bit 30.
  - IP_HW = [10 +: NUM_HWINT], tracks HWInt every cycle.
  - IP_SW = [9:8], software-writable.
  - ExcCode = [6:2].
  - An mtc0 to Cause writes IP_SW only.
- Pending set: pend = IM & {IP_HW with bit [NUM_HWINT-1] ORed with TI, IP_SW}.
- Request logic:
  - IntReq = |pend & IE & !EXL.
  - ExcReq = (ExcCodeIn != 0) & !EXL.
  - Req = IntReq | ExcReq.
- On a Req cycle, at the next clock edge:
  - EXL <= 1.
  - BD <= BDIn.
  - EPC <= BDIn ? VPC-4 : VPC.
  - ExcCode <= IntReq ? 0 : ExcCodeIn; an interrupt has priority over an exception.
  - BadVAddr <= BadVAddrIn, only if !IntReq and ExcCodeIn ∈ {4, 5}.
- EPCOut = Req ? (BDIn ? VPC-4 : VPC) : EPC. The same-cycle value is used by the handler entry.
- mtc0 write:
  - Happens when enable and !Req; if Req=1 in the same cycle the write is dropped.
  - A write to EPC forces bits [1:0] to 0.
- EXLClr: clears EXL at the clock edge. If Req is also asserted that cycle, Req wins and EXL ends at 1.
- Timer (TIMER_EN=1):
  - Count increments by 1 every clock and wraps 32'hFFFF_FFFF -> 0.
  - An mtc0 to Count loads CP0In; that cycle's increment is suppressed.
  - TI sets when the next value of Count equals Compare. TI is sticky.
  - TI clears on any mtc0 to Compare. If that write and a match occur in the same cycle, the clear wins.
- Read-after-write: CP0Out reflects the registered value. There is no bypass of same-cycle writes.

Decomposition:
- Shared package cp0_pkg holds:
  - register address constants;
  - ExcCode constants (INT=0, AdEL=4, AdES=5, RI=10, Ov=12);
  - SR/Cause bit-position localparams.
- Sub-module cp0_timer holds Count, Compare and TI.
  - Inputs: write strobes/data and the Compare-write clear.
  - Outputs: Count, Compare, TI.
  - Instantiated only when TIMER_EN=1.

Test Plan:
- Reset, then SR=32'h0000_0401, HWInt[0]=1, VPC=32'h3010 -> Req=1 same cycle; EPCOut=32'h3010. Next cycle: EXL=1, ExcCode=0, Req=0.
- ExcCodeIn=4, BDIn=1, VPC=32'h3024, BadVAddrIn=32'h1001 -> EPC=32'h3020, BD=1, BadVAddr=32'h1001, Cause[6:2]=4.
- Interrupt pending and ExcCodeIn=12 in the same cycle -> ExcCode=0; BadVAddr unchanged.
- mtc0 SR and Req in the same cycle -> SR unchanged. Then eret (EXLClr) with Req=0 -> EXL=0.
- Compare=32'd20, Count=0, SR=32'h0000_8001 (NUM_HWINT=6) -> TI set when Count reaches 20; Req asserts. A write to Compare clears TI.
- Software interrupt: mtc0 Cause=32'h100, SR=32'h101 -> Req=1, ExcCode=0. Reset asserted mid-handler -> all registers back to reset values immediately.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register addresses, exception codes and SR/Cause field positions.
package cp0_pkg;

    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_SR       = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;
    localparam logic [4:0] ADDR_PRID     = 5'd15;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    localparam int unsigned SR_IE        = 0;
    localparam int unsigned SR_EXL       = 1;
    localparam int unsigned IM_SW_LO     = 8;
    localparam int unsigned IM_HW_LO     = 10;
    localparam int unsigned CAUSE_EXC_LO = 2;
    localparam int unsigned IP_SW_LO     = 8;
    localparam int unsigned IP_HW_LO     = 10;
    localparam int unsigned CAUSE_TI     = 30;
    localparam int unsigned CAUSE_BD     = 31;

endpackage

// File: rtl/cp0_ext_if.sv
// Pipeline <-> CP0 bus: mtc0/mfc0 access, M-stage exception info and the flush request.
interface cp0_ext_if;

    logic        enable;
    logic [4:0]  CP0Address;
    logic [31:0] CP0In;
    logic [31:0] CP0Out;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [31:0] BadVAddrIn;
    logic        EXLClr;
    logic [31:0] EPCOut;
    logic        Req;

    modport master (
        output enable, CP0Address, CP0In, VPC, BDIn, ExcCodeIn, BadVAddrIn, EXLClr,
        input  CP0Out, EPCOut, Req
    );

    modport slave (
        input  enable, CP0Address, CP0In, VPC, BDIn, ExcCodeIn, BadVAddrIn, EXLClr,
        output CP0Out, EPCOut, Req
    );

endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer: free-running Count, Compare and the sticky timer interrupt TI.
module cp0_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q, ti_d;

    always_comb begin
        count_d   = count_we ? wdata : count_q + 32'd1;
        compare_d = compare_we ? wdata : compare_q;
        // Match is against the outgoing Compare; a Compare write clears TI even on a coincident match.
        ti_d      = compare_we ? 1'b0 : (ti_q | (count_d == compare_q));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q   <= '0;
            compare_q <= '1;
            ti_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign ti      = ti_q;

endmodule

// File: rtl/cp0_ext.sv
// Coprocessor 0: status/cause/EPC registers, exception and interrupt arbitration, optional timer.
module cp0_ext
    import cp0_pkg::*;
#(
    parameter int unsigned NUM_HWINT = 6,
    parameter bit          TIMER_EN  = 1'b1,
    parameter logic [31:0] PRID      = 32'h0000_4B50
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_HWINT-1:0] HWInt,
    cp0_ext_if.slave             bus
);

    localparam logic [31:0] SR_WMASK =
        (((32'd1 << NUM_HWINT) - 32'd1) << IM_HW_LO) | 32'h0000_0303;

    logic [31:0]          sr_q, sr_d;
    logic [31:0]          epc_q, epc_d;
    logic [31:0]          badvaddr_q, badvaddr_d;
    logic                 bd_q, bd_d;
    logic [1:0]           ip_sw_q, ip_sw_d;
    logic [NUM_HWINT-1:0] ip_hw_q, ip_hw_d;
    logic [4:0]           exc_code_q, exc_code_d;

    logic [31:0]          count, compare;
    logic                 ti;
    logic [NUM_HWINT-1:0] hw_line;
    logic                 int_req, exc_req, req, wr;
    logic                 count_we, compare_we;
    logic [31:0]          epc_target, cause;

    always_comb begin
        // TI shares the topmost hardware interrupt line.
        hw_line = ip_hw_q;
        hw_line[NUM_HWINT-1] = ip_hw_q[NUM_HWINT-1] | ti;
        int_req = ((|(hw_line & sr_q[IM_HW_LO +: NUM_HWINT])) |
                   (|(ip_sw_q & sr_q[IM_SW_LO +: 2]))) & sr_q[SR_IE] & ~sr_q[SR_EXL];
        exc_req    = (bus.ExcCodeIn != EXC_INT) & ~sr_q[SR_EXL];
        req        = int_req | exc_req;
        wr         = bus.enable & ~req;
        epc_target = bus.BDIn ? bus.VPC - 32'd4 : bus.VPC;
        count_we   = wr & (bus.CP0Address == ADDR_COUNT);
        compare_we = wr & (bus.CP0Address == ADDR_COMPARE);
    end

    always_comb begin
        sr_d       = sr_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        bd_d       = bd_q;
        ip_sw_d    = ip_sw_q;
        ip_hw_d    = HWInt;
        exc_code_d = exc_code_q;
        if (req) begin
            sr_d[SR_EXL] = 1'b1;
            bd_d         = bus.BDIn;
            epc_d        = epc_target;
            exc_code_d   = int_req ? 5'(EXC_INT) : bus.ExcCodeIn;
            if (!int_req && (bus.ExcCodeIn == EXC_ADEL || bus.ExcCodeIn == EXC_ADES)) begin
                badvaddr_d = bus.BadVAddrIn;
            end
        end else begin
            if (wr) begin
                case (bus.CP0Address)
                    ADDR_SR:    sr_d    = bus.CP0In & SR_WMASK;
                    ADDR_CAUSE: ip_sw_d = bus.CP0In[IP_SW_LO +: 2];
                    ADDR_EPC:   epc_d   = {bus.CP0In[31:2], 2'b00};
                    default:    ;
                endcase
            end
            if (bus.EXLClr) begin
                sr_d[SR_EXL] = 1'b0;
            end
        end
    end

    always_comb begin
        cause                            = '0;
        cause[CAUSE_BD]                  = bd_q;
        cause[CAUSE_TI]                  = ti;
        cause[IP_HW_LO +: NUM_HWINT]     = ip_hw_q;
        cause[IP_SW_LO +: 2]             = ip_sw_q;
        cause[CAUSE_EXC_LO +: 5]         = exc_code_q;
        case (bus.CP0Address)
            ADDR_BADVADDR: bus.CP0Out = badvaddr_q;
            ADDR_COUNT:    bus.CP0Out = count;
            ADDR_COMPARE:  bus.CP0Out = compare;
            ADDR_SR:       bus.CP0Out = sr_q;
            ADDR_CAUSE:    bus.CP0Out = cause;
            ADDR_EPC:      bus.CP0Out = epc_q;
            ADDR_PRID:     bus.CP0Out = PRID;
            default:       bus.CP0Out = '0;
        endcase
        bus.Req    = req;
        bus.EPCOut = req ? epc_target : epc_q;
    end

    generate
        if (TIMER_EN) begin : g_timer
            cp0_timer u_timer (
                .clk        (clk),
                .reset      (reset),
                .count_we   (count_we),
                .compare_we (compare_we),
                .wdata      (bus.CP0In),
                .count      (count),
                .compare    (compare),
                .ti         (ti)
            );
        end else begin : g_no_timer
            assign count   = '0;
            assign compare = '0;
            assign ti      = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q       <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
            bd_q       <= 1'b0;
            ip_sw_q    <= '0;
            ip_hw_q    <= '0;
            exc_code_q <= '0;
        end else begin
            sr_q       <= sr_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            bd_q       <= bd_d;
            ip_sw_q    <= ip_sw_d;
            ip_hw_q    <= ip_hw_d;
            exc_code_q <= exc_code_d;
        end
    end

endmodule

// File: tb/tb_cp0_ext.sv
// Bench for cp0_ext: directed vector table, timer/reset sequences, randomized run against a register-file model.
module tb_cp0_ext;
    import cp0_pkg::*;

    localparam int unsigned NHW = 6;
    localparam logic [31:0] PRID_V = 32'h0000_4B50;

    logic clk = 1'b0;
    logic rst_n;
    logic [NHW-1:0] hwint;
    cp0_ext_if bus();

    cp0_ext #(.NUM_HWINT(NHW), .TIMER_EN(1'b1), .PRID(PRID_V)) dut (
        .clk   (clk),
        .reset (rst_n),
        .HWInt (hwint),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] din;
        logic [31:0] vpc;
        logic        bd;
        logic [4:0]  exc;
        logic [31:0] badv;
        logic [5:0]  hw;
        logic        eclr;
    } vin_t;

    typedef struct {
        vin_t        v;
        logic        req;
        logic [31:0] epc;
        logic [31:0] rdv;
    } vec_t;

    int n_pass = 0;
    int n_total = 0;
    logic [31:0] m [32];

    function automatic vin_t vi(logic en, logic [4:0] a, logic [31:0] d, logic [31:0] pc,
                                logic bd, logic [4:0] exc, logic [31:0] bv, logic [5:0] hw, logic ec);
        vin_t v;
        v.en = en; v.addr = a; v.din = d; v.vpc = pc; v.bd = bd;
        v.exc = exc; v.badv = bv; v.hw = hw; v.eclr = ec;
        return v;
    endfunction

    function automatic vin_t rd(logic [4:0] a);
        return vi(1'b0, a, 0, 0, 1'b0, 0, 0, 0, 1'b0);
    endfunction

    function automatic vin_t wr(logic [4:0] a, logic [31:0] d);
        return vi(1'b1, a, d, 0, 1'b0, 0, 0, 0, 1'b0);
    endfunction

    task automatic apply(input vin_t v);
        bus.enable     = v.en;
        bus.CP0Address = v.addr;
        bus.CP0In      = v.din;
        bus.VPC        = v.vpc;
        bus.BDIn       = v.bd;
        bus.ExcCodeIn  = v.exc;
        bus.BadVAddrIn = v.badv;
        bus.EXLClr     = v.eclr;
        hwint          = v.hw;
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        apply(rd(0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference model: architectural register file indexed by CP0 address.
    function automatic logic mdl_int();
        logic [7:0] ip;
        ip = m[13][15:8];
        if (m[13][30]) ip[7] = 1'b1;
        return (|(ip & m[12][15:8])) && m[12][0] && !m[12][1];
    endfunction

    function automatic logic mdl_req(vin_t v);
        return mdl_int() || ((v.exc != 0) && !m[12][1]);
    endfunction

    function automatic logic [31:0] mdl_rd(logic [4:0] a);
        if (a == 8 || a == 9 || a == 11 || a == 12 || a == 13 || a == 14) return m[a];
        if (a == 15) return PRID_V;
        return 32'd0;
    endfunction

    task automatic mdl_step(input vin_t v);
        logic [31:0] n [32];
        logic intr, req, wen, ti;
        logic [31:0] cnt_next;
        intr = mdl_int();
        req  = mdl_req(v);
        n    = m;
        wen  = v.en && !req;
        cnt_next = (wen && v.addr == 9) ? v.din : m[9] + 1;
        n[9] = cnt_next;
        ti = (wen && v.addr == 11) ? 1'b0 : (m[13][30] || cnt_next == m[11]);
        if (wen) begin
            if (v.addr == 11) n[11] = v.din;
            if (v.addr == 12) n[12] = v.din & 32'h0000_FF03;
            if (v.addr == 13) n[13][9:8] = v.din[9:8];
            if (v.addr == 14) n[14] = v.din & 32'hFFFF_FFFC;
        end
        if (!req && v.eclr) n[12][1] = 1'b0;
        if (req) begin
            n[12][1] = 1'b1;
            n[13][31] = v.bd;
            n[13][6:2] = intr ? 5'd0 : v.exc;
            n[14] = v.bd ? v.vpc - 4 : v.vpc;
            if (!intr && (v.exc == 4 || v.exc == 5)) n[8] = v.badv;
        end
        n[13][30] = ti;
        n[13][15:10] = v.hw;
        m = n;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        vin_t v;
        logic found, hit;
        logic [31:0] fire_cnt;
        logic [5:0] hw_prev;

        tbl.push_back('{vi(0,12,0,0,0,0,0,0,0),                 1'b0, 32'h0,    32'h0});
        tbl.push_back('{vi(1,12,'h401,'h3000,0,0,0,1,0),        1'b0, 32'h0,    32'h0});
        tbl.push_back('{vi(0,12,0,'h3010,0,0,0,1,0),            1'b1, 32'h3010, 32'h401});
        tbl.push_back('{vi(0,13,0,'h3014,0,0,0,1,0),            1'b0, 32'h3010, 32'h400});
        tbl.push_back('{vi(0,12,0,0,0,0,0,1,0),                 1'b0, 32'h3010, 32'h403});
        tbl.push_back('{vi(0,14,0,0,0,0,0,0,1),                 1'b0, 32'h3010, 32'h3010});
        tbl.push_back('{vi(0,12,0,'h3024,1,4,'h1001,0,0),       1'b1, 32'h3020, 32'h401});
        tbl.push_back('{vi(0,14,0,0,0,0,0,0,0),                 1'b0, 32'h3020, 32'h3020});
        tbl.push_back('{vi(0,8,0,0,0,0,0,0,0),                  1'b0, 32'h3020, 32'h1001});
        tbl.push_back('{vi(0,13,0,0,0,0,0,0,1),                 1'b0, 32'h3020, 32'h8000_0010});
        tbl.push_back('{vi(0,12,0,0,0,0,0,1,0),                 1'b0, 32'h3020, 32'h401});
        tbl.push_back('{vi(0,8,0,'h3040,0,12,'hDEAD0000,1,0),   1'b1, 32'h3040, 32'h1001});
        tbl.push_back('{vi(0,13,0,0,0,0,0,1,0),                 1'b0, 32'h3040, 32'h400});
        tbl.push_back('{vi(0,8,0,0,0,0,0,0,0),                  1'b0, 32'h3040, 32'h1001});
        tbl.push_back('{vi(0,12,0,0,0,0,0,0,1),                 1'b0, 32'h3040, 32'h403});
        tbl.push_back('{vi(1,12,'hFF01,'h3050,0,10,0,0,0),      1'b1, 32'h3050, 32'h401});
        tbl.push_back('{vi(0,12,0,0,0,0,0,0,0),                 1'b0, 32'h3050, 32'h403});
        tbl.push_back('{vi(0,13,0,0,0,0,0,0,1),                 1'b0, 32'h3050, 32'h28});
        tbl.push_back('{vi(0,12,0,0,0,0,0,0,0),                 1'b0, 32'h3050, 32'h401});
        tbl.push_back('{vi(1,14,'h1237,0,0,0,0,0,0),            1'b0, 32'h3050, 32'h3050});
        tbl.push_back('{vi(0,14,0,0,0,0,0,0,0),                 1'b0, 32'h1234, 32'h1234});
        tbl.push_back('{vi(0,15,0,0,0,0,0,0,0),                 1'b0, 32'h1234, 32'h4B50});
        tbl.push_back('{vi(1,3,'hFFFF_FFFF,0,0,0,0,0,0),        1'b0, 32'h1234, 32'h0});
        tbl.push_back('{vi(0,3,0,0,0,0,0,0,0),                  1'b0, 32'h1234, 32'h0});
        tbl.push_back('{vi(1,8,0,0,0,0,0,0,0),                  1'b0, 32'h1234, 32'h1001});
        tbl.push_back('{vi(0,8,0,0,0,0,0,0,0),                  1'b0, 32'h1234, 32'h1001});

        // Reset state
        rst_n = 1'b0;
        apply(rd(0));
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            logic [4:0] a;
            case (i)
                0: a = ADDR_BADVADDR;
                1: a = ADDR_COUNT;
                2: a = ADDR_COMPARE;
                3: a = ADDR_SR;
                4: a = ADDR_CAUSE;
                default: a = ADDR_EPC;
            endcase
            apply(rd(a));
            chk($sformatf("reset_rd%0d", a), bus.CP0Out, (a == ADDR_COMPARE) ? 32'hFFFF_FFFF : 32'h0);
        end
        chk("reset_req", 32'(bus.Req), 32'd0);
        chk("reset_epcout", bus.EPCOut, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].v);
            chk($sformatf("vec%0d_req", i), 32'(bus.Req), 32'(tbl[i].req));
            chk($sformatf("vec%0d_epcout", i), bus.EPCOut, tbl[i].epc);
            chk($sformatf("vec%0d_rd", i), bus.CP0Out, tbl[i].rdv);
            @(negedge clk);
        end

        // Timer: Compare=20, Count=0, IM7 + IE
        do_reset();
        apply(wr(ADDR_COMPARE, 32'd20)); @(negedge clk);
        apply(wr(ADDR_COUNT, 32'd0));    @(negedge clk);
        apply(wr(ADDR_SR, 32'h0000_8001)); @(negedge clk);
        found = 1'b0;
        fire_cnt = '0;
        for (int i = 0; i < 40 && !found; i++) begin
            apply(rd(ADDR_COUNT));
            if (i == 0) chk("count_after_load", bus.CP0Out, 32'd1);
            if (bus.Req) begin
                found = 1'b1;
                fire_cnt = bus.CP0Out;
            end
            @(negedge clk);
        end
        chk("timer_fired", 32'(found), 32'd1);
        chk("timer_fire_count", fire_cnt, 32'd20);
        apply(rd(ADDR_CAUSE));
        chk("timer_cause", bus.CP0Out, 32'h4000_0000);
        chk("timer_req_after", 32'(bus.Req), 32'd0);
        @(negedge clk);
        apply(wr(ADDR_COMPARE, 32'd100)); @(negedge clk);
        apply(rd(ADDR_CAUSE));
        chk("ti_cleared", bus.CP0Out, 32'h0);
        @(negedge clk);
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            apply(rd(ADDR_COUNT));
            if (bus.CP0Out == 32'd98) hit = 1'b1;
            @(negedge clk);
        end
        chk("count_reached_98", 32'(hit), 32'd1);
        apply(wr(ADDR_COMPARE, 32'd500)); @(negedge clk);
        apply(rd(ADDR_CAUSE));
        chk("ti_clear_wins", bus.CP0Out, 32'h0);
        @(negedge clk);
        apply(rd(ADDR_COMPARE));
        chk("compare_rd", bus.CP0Out, 32'd500);
        @(negedge clk);

        // Software interrupt, then reset mid-handler
        do_reset();
        apply(wr(ADDR_CAUSE, 32'h100)); @(negedge clk);
        apply(wr(ADDR_SR, 32'h101));
        chk("swi_req_pre", 32'(bus.Req), 32'd0);
        @(negedge clk);
        apply(vi(0, ADDR_SR, 0, 32'h4000, 0, 0, 0, 0, 0));
        chk("swi_req", 32'(bus.Req), 32'd1);
        chk("swi_epcout", bus.EPCOut, 32'h4000);
        chk("swi_sr", bus.CP0Out, 32'h101);
        @(negedge clk);
        apply(rd(ADDR_CAUSE));
        chk("swi_cause", bus.CP0Out, 32'h100);
        chk("swi_req_post", 32'(bus.Req), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_cause", bus.CP0Out, 32'h0);
        chk("midrst_req", 32'(bus.Req), 32'd0);
        bus.CP0Address = ADDR_SR; #1;
        chk("midrst_sr", bus.CP0Out, 32'h0);
        bus.CP0Address = ADDR_EPC; #1;
        chk("midrst_epc", bus.CP0Out, 32'h0);

        // Randomized run against the model
        do_reset();
        for (int i = 0; i < 32; i++) m[i] = '0;
        m[11] = '1;
        hw_prev = '0;
        for (int i = 0; i < 400; i++) begin
            v.en = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 7))
                0: v.addr = 5'd8;
                1: v.addr = 5'd9;
                2: v.addr = 5'd11;
                3: v.addr = 5'd12;
                4: v.addr = 5'd13;
                5: v.addr = 5'd14;
                6: v.addr = 5'd15;
                default: v.addr = 5'($urandom_range(0, 31));
            endcase
            v.din = $urandom;
            if (v.addr == 9 && $urandom_range(0, 1) == 1) v.din = m[11] - $urandom_range(0, 3);
            v.vpc = $urandom & 32'hFFFF_FFFC;
            v.bd = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 23))
                0: v.exc = 5'd4;
                1: v.exc = 5'd5;
                2: v.exc = EXC_RI;
                3: v.exc = EXC_OV;
                default: v.exc = 5'd0;
            endcase
            v.badv = $urandom;
            if ($urandom_range(0, 3) == 0) hw_prev = 6'($urandom);
            v.hw = hw_prev;
            v.eclr = ($urandom_range(0, 2) == 0);
            apply(v);
            chk($sformatf("rnd%0d_req", i), 32'(bus.Req), 32'(mdl_req(v)));
            chk($sformatf("rnd%0d_epcout", i), bus.EPCOut,
                mdl_req(v) ? (v.bd ? v.vpc - 32'd4 : v.vpc) : m[14]);
            chk($sformatf("rnd%0d_rd%0d", i, v.addr), bus.CP0Out, mdl_rd(v.addr));
            mdl_step(v);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
